// File: rtl/mask_packer.sv
// Packs a 1-bit result stream into MASK_W-bit mask words on a valid/ready stream,
// with the accumulator and output register forming a double buffer. Optional MASK_POPCNT_EN adds mask_popcnt.
module mask_packer #(
    parameter  int MASK_W = 32,
    parameter  int IDX_W  = 16,
    localparam int CNT_W  = $clog2(MASK_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic              res_bit,
    input  logic              res_last,
    output logic              mask_valid,
    input  logic              mask_ready,
    output logic [MASK_W-1:0] mask_data,
    output logic [CNT_W-1:0]  mask_count,
    output logic              mask_last,
`ifdef MASK_POPCNT_EN
    output logic [CNT_W-1:0]  mask_popcnt,
`endif
    output logic [IDX_W-1:0]  mask_index
);

    localparam int AW = $clog2(MASK_W);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(MASK_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STALL} state_e;

    state_e             state_q, state_d;
    logic [MASK_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   accCnt_q, accCnt_d;
    logic               pendLast_q, pendLast_d;
    logic               valid_q, valid_d;
    logic [MASK_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               accept, outFree, load, loadLast;
    logic [MASK_W-1:0]  accNew, loadData;
    logic [CNT_W-1:0]   loadCount;

    assign res_ready  = (state_q == S_FILL);
    assign accept     = res_valid & res_ready;
    assign outFree    = ~valid_q | mask_ready;

    assign mask_valid = valid_q;
    assign mask_data  = data_q;
    assign mask_count = count_q;
    assign mask_last  = last_q;
    assign mask_index = index_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        accCnt_d   = accCnt_q;
        pendLast_d = pendLast_q;
        valid_d    = valid_q;
        data_d     = data_q;
        count_d    = count_q;
        last_d     = last_q;
        index_d    = index_q;
        idx_d      = idx_q;
        accNew     = acc_q;
        load       = 1'b0;
        loadData   = acc_q;
        loadCount  = accCnt_q;
        loadLast   = pendLast_q;

        if (valid_q && mask_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_FILL;
            S_FILL: begin
                if (accept) begin
                    accNew[accCnt_q[AW-1:0]] = res_bit;
                    acc_d    = accNew;
                    accCnt_d = accCnt_q + 1'b1;
                    if (accCnt_q == LAST_POS || res_last) begin
                        if (outFree) begin
                            load      = 1'b1;
                            loadData  = accNew;
                            loadCount = accCnt_q + 1'b1;
                            loadLast  = res_last;
                            acc_d     = '0;
                            accCnt_d  = '0;
                        end else begin
                            // Completed word parks in the accumulator until the output frees up
                            state_d    = S_STALL;
                            pendLast_d = res_last;
                        end
                    end
                end
            end
            S_STALL: begin
                if (valid_q && mask_ready) begin
                    load       = 1'b1;
                    acc_d      = '0;
                    accCnt_d   = '0;
                    pendLast_d = 1'b0;
                    state_d    = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            valid_d = 1'b1;
            data_d  = loadData;
            count_d = loadCount;
            last_d  = loadLast;
            index_d = idx_q;
            idx_d   = loadLast ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            accCnt_q   <= '0;
            pendLast_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            index_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            accCnt_q   <= accCnt_d;
            pendLast_q <= pendLast_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            count_q    <= count_d;
            last_q     <= last_d;
            index_q    <= index_d;
            idx_q      <= idx_d;
        end
    end

`ifdef MASK_POPCNT_EN
    logic [CNT_W-1:0] popcnt_q, popcnt_d;

    always_comb begin
        popcnt_d = popcnt_q;
        if (load) begin
            popcnt_d = '0;
            for (int i = 0; i < MASK_W; i++) begin
                popcnt_d = popcnt_d + CNT_W'(loadData[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            popcnt_q <= '0;
        end else begin
            popcnt_q <= popcnt_d;
        end
    end

    assign mask_popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_mask_packer.sv
// Self-checking bench for mask_packer: directed scenarios plus a randomized run
// checked against a queue-based reference model of the packing rules.
module tb_mask_packer;

    localparam int MASK_W = 32;
    localparam int IDX_W  = 16;
    localparam int CNT_W  = $clog2(MASK_W) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              res_valid = 1'b0;
    logic              res_ready;
    logic              res_bit = 1'b0;
    logic              res_last = 1'b0;
    logic              mask_valid;
    logic              mask_ready = 1'b0;
    logic [MASK_W-1:0] mask_data;
    logic [CNT_W-1:0]  mask_count;
    logic              mask_last;
    logic [IDX_W-1:0]  mask_index;
`ifdef MASK_POPCNT_EN
    logic [CNT_W-1:0]  mask_popcnt;
`endif

    mask_packer #(.MASK_W(MASK_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_bit    (res_bit),
        .res_last   (res_last),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask_data  (mask_data),
        .mask_count (mask_count),
        .mask_last  (mask_last),
`ifdef MASK_POPCNT_EN
        .mask_popcnt(mask_popcnt),
`endif
        .mask_index (mask_index)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    typedef struct {
        logic [MASK_W-1:0] data;
        int                count;
        bit                last;
        int                index;
    } word_t;

    word_t             expQ[$];
    logic [MASK_W-1:0] mAcc = '0;
    int                mCnt = 0;
    int                mIdx = 0;
    bit                prevHold = 0;
    word_t             holdW;

    // Reference model: collect accepted bits, queue finished words, compare on each handshake
    always @(negedge clk) begin
        word_t w;
        if (!reset) begin
            expQ.delete();
            mAcc = '0;
            mCnt = 0;
            mIdx = 0;
            prevHold = 0;
        end else begin
            if (prevHold) begin
                checkOutput("holdValid", 64'(mask_valid), 64'd1);
                checkOutput("holdData",  64'(mask_data),  64'(holdW.data));
                checkOutput("holdCount", 64'(mask_count), 64'(holdW.count));
                checkOutput("holdLast",  64'(mask_last),  64'(holdW.last));
                checkOutput("holdIndex", 64'(mask_index), 64'(holdW.index));
`ifdef MASK_POPCNT_EN
                checkOutput("holdPopcnt", 64'(mask_popcnt), 64'($countones(holdW.data)));
`endif
            end
            if (mask_valid && mask_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWord", 64'(expQ.size()), 64'd1);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("wordData",  64'(mask_data),  64'(w.data));
                    checkOutput("wordCount", 64'(mask_count), 64'(w.count));
                    checkOutput("wordLast",  64'(mask_last),  64'(w.last));
                    checkOutput("wordIndex", 64'(mask_index), 64'(w.index));
`ifdef MASK_POPCNT_EN
                    checkOutput("wordPopcnt", 64'(mask_popcnt), 64'($countones(w.data)));
`endif
                end
            end
            if (res_valid && res_ready) begin
                mAcc[mCnt] = res_bit;
                mCnt++;
                if (mCnt == MASK_W || res_last) begin
                    w.data  = mAcc;
                    w.count = mCnt;
                    w.last  = res_last;
                    w.index = mIdx;
                    expQ.push_back(w);
                    mIdx = res_last ? 0 : (mIdx + 1) % (1 << IDX_W);
                    mAcc = '0;
                    mCnt = 0;
                end
            end
            prevHold = mask_valid && !mask_ready;
            holdW.data  = mask_data;
            holdW.count = int'(mask_count);
            holdW.last  = mask_last;
            holdW.index = int'(mask_index);
        end
    end

    task automatic applyStimulus(input logic b, input logic l);
        logic rdy;
        bit   done = 0;
        res_valid = 1'b1;
        res_bit   = b;
        res_last  = l;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            rdy = res_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        if (!done) checkOutput("acceptTimeout", 64'd0, 64'd1);
        res_valid = 1'b0;
        res_last  = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic checkWord(input string tag, input logic [MASK_W-1:0] d, input int c, input logic l, input int idx);
        checkOutput({tag, "Valid"}, 64'(mask_valid), 64'd1);
        checkOutput({tag, "Data"},  64'(mask_data),  64'(d));
        checkOutput({tag, "Count"}, 64'(mask_count), 64'(c));
        checkOutput({tag, "Last"},  64'(mask_last),  64'(l));
        checkOutput({tag, "Index"}, 64'(mask_index), 64'(idx));
    endtask

    initial begin
        logic [MASK_W-1:0] w1, w2, pat;
        w1 = 32'hDEADBEEF;
        w2 = 32'h12345678;
        pat = 5'b11011;

        #2;
        checkOutput("rstReady", 64'(res_ready),  64'd0);
        checkOutput("rstValid", 64'(mask_valid), 64'd0);
        checkOutput("rstData",  64'(mask_data),  64'd0);
        checkOutput("rstCount", 64'(mask_count), 64'd0);
        checkOutput("rstLast",  64'(mask_last),  64'd0);
        checkOutput("rstIndex", 64'(mask_index), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Alternating 32-bit word, visible the cycle after its last bit is accepted
        mask_ready = 1'b1;
        for (int i = 0; i < MASK_W; i++) begin
            if (i == MASK_W - 1) checkOutput("t1ValidEarly", 64'(mask_valid), 64'd0);
            applyStimulus(logic'(i % 2 == 0), 1'b0);
        end
        checkWord("t1", 32'h55555555, 32, 1'b0, 0);
`ifdef MASK_POPCNT_EN
        checkOutput("t1Popcnt", 64'(mask_popcnt), 64'd16);
`endif

        // Short column closed by res_last, then a fresh column starts at index 0
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(pat[i], logic'(i == 4));
        checkWord("t2", 32'h1B, 5, 1'b1, 0);
`ifdef MASK_POPCNT_EN
        checkOutput("t2Popcnt", 64'(mask_popcnt), 64'd4);
`endif
        applyStimulus(1'b1, 1'b1);
        checkWord("t2Next", 32'h1, 1, 1'b1, 0);

        // Backpressure: two full words with the output blocked
        doReset();
        mask_ready = 1'b0;
        for (int i = 0; i < MASK_W; i++) applyStimulus(w1[i], 1'b0);
        for (int i = 0; i < MASK_W; i++) applyStimulus(w2[i], 1'b0);
        checkOutput("t3ReadyLow", 64'(res_ready), 64'd0);
        checkWord("t3Held", w1, 32, 1'b0, 0);
        mask_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t3ReadyBack", 64'(res_ready), 64'd1);
        checkWord("t3Second", w2, 32, 1'b0, 1);
        @(posedge clk);
        #1;
        checkOutput("t3Drained", 64'(mask_valid), 64'd0);

        // One-bit columns: each word loads on the edge the previous one hands off
        doReset();
        mask_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(logic'(i[0]), 1'b1);
            checkOutput("t4Ready", 64'(res_ready), 64'd1);
            checkWord("t4", MASK_W'(i[0]), 1, 1'b1, 0);
        end

        // Reset mid-word discards the partial and clears outputs immediately
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(logic'($urandom_range(0, 1)), 1'b0);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("t5Ready", 64'(res_ready),  64'd0);
        checkOutput("t5Valid", 64'(mask_valid), 64'd0);
        checkOutput("t5Data",  64'(mask_data),  64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkWord("t5", 32'h5, 3, 1'b1, 0);

        // Randomized traffic against the reference model
        doReset();
        for (int c = 0; c < 4000; c++) begin
            res_valid  = logic'($urandom_range(0, 3) != 0);
            res_bit    = logic'($urandom_range(0, 1));
            res_last   = logic'($urandom_range(0, 19) == 0);
            mask_ready = logic'($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        res_valid  = 1'b0;
        res_last   = 1'b0;
        mask_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("drainQueue", 64'(expQ.size()), 64'd0);
        checkOutput("drainValid", 64'(mask_valid), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
